// File: rtl/axi_lite_ram_ctrl_if.sv
// rtl/axi_lite_ram_ctrl_if.sv - AXI4-Lite subordinate bus bundle for the RAM front-end
interface axi_lite_ram_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 10
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [STRB_WIDTH-1:0]     s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_ram_ctrl.sv
// rtl/axi_lite_ram_ctrl.sv - AXI4-Lite subordinate driving a byte-enabled 1-cycle-latency RAM
// Independent write and read FSMs; one write and one read may be in flight together.
module axi_lite_ram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + $clog2(STRB_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_ram_ctrl_if.slave    s,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic                  mem_cs,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  localparam int OFF = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_CAP, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic     aw_held;
  logic     w_held;
  logic     aw_hs;
  logic     w_hs;
  logic     ar_hs;
  logic     unused_offset_bits;

  assign s.s_awready = !rst && (w_state == W_IDLE) && !aw_held;
  assign s.s_wready  = !rst && (w_state == W_IDLE) && !w_held;
  assign s.s_arready = !rst && (r_state == R_IDLE);
  assign s.s_bresp   = 2'b00;
  assign s.s_rresp   = 2'b00;
  assign mem_cs      = mem_wr | mem_rd;

  assign aw_hs = s.s_awvalid && s.s_awready;
  assign w_hs  = s.s_wvalid && s.s_wready;
  assign ar_hs = s.s_arvalid && s.s_arready;

  assign unused_offset_bits = ^{s.s_awaddr[OFF-1:0], s.s_araddr[OFF-1:0]};

  // The mem_wr_* registers double as the AW/W latches, so they are already
  // presented to the RAM when the W_MEM cycle strobes mem_wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_be      <= '0;
      s.s_bvalid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            mem_wr_addr <= s.s_awaddr[AXI_ADDR_WIDTH-1:OFF];
            aw_held     <= 1'b1;
          end
          if (w_hs) begin
            mem_wr_data <= s.s_wdata;
            mem_be      <= s.s_wstrb;
            w_held      <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            mem_wr  <= 1'b1;
            w_state <= W_MEM;
          end
        end
        W_MEM: begin
          mem_wr     <= 1'b0;
          aw_held    <= 1'b0;
          w_held     <= 1'b0;
          s.s_bvalid <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (s.s_bready) begin
            s.s_bvalid <= 1'b0;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM data is valid the cycle after mem_rd, which is the R_CAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      mem_rd      <= 1'b0;
      mem_rd_addr <= '0;
      s.s_rdata   <= '0;
      s.s_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            mem_rd_addr <= s.s_araddr[AXI_ADDR_WIDTH-1:OFF];
            mem_rd      <= 1'b1;
            r_state     <= R_MEM;
          end
        end
        R_MEM: begin
          mem_rd  <= 1'b0;
          r_state <= R_CAP;
        end
        R_CAP: begin
          s.s_rdata  <= mem_rd_data;
          s.s_rvalid <= 1'b1;
          r_state    <= R_RESP;
        end
        R_RESP: begin
          if (s.s_rready) begin
            s.s_rvalid <= 1'b0;
            r_state    <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// tb/tb_axi_lite_ram_ctrl.sv - directed self-checking bench with shadow-memory model
module tb_axi_lite_ram_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;
  localparam int AAW = 10;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] b;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_ram_ctrl_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AAW)) bus ();

  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic          mem_wr, mem_rd, mem_cs;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic [SW-1:0] mem_be;

  axi_lite_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .s(bus.slave),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wr_data(mem_wr_data),
    .mem_be(mem_be), .mem_cs(mem_cs), .mem_rd_data(mem_rd_data)
  );

  // RAM macro: registered read, read-before-write on same-cycle collisions
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_rd) mem_rd_data <= ram[mem_rd_addr];
    if (mem_wr)
      for (int k = 0; k < SW; k++)
        if (mem_be[k]) ram[mem_wr_addr][8*k +: 8] <= mem_wr_data[8*k +: 8];
  end

  // Model: shadow memory updated when a write response is accepted;
  // a read's expected data is the shadow contents when its AR is issued.
  logic [DW-1:0] shadow [2**AW];
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] b);
    for (int k = 0; k < SW; k++)
      if (b[k]) shadow[a][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic          prev_rv, prev_rrdy, prev_bv, prev_brdy;
  logic [DW-1:0] prev_rdata;
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      prev_bv = 1'b0;
    end else begin
      wr_t e;
      chk("mem_cs", {31'd0, mem_cs}, {31'd0, mem_wr | mem_rd});
      if (mem_wr) begin
        if (exp_wr.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("mem_wr_addr", {24'd0, mem_wr_addr}, {24'd0, e.a});
          chk("mem_wr_data", mem_wr_data, e.d);
          chk("mem_be", {28'd0, mem_be}, {28'd0, e.b});
        end
      end
      if (bus.s_bvalid) chk("bresp", {30'd0, bus.s_bresp}, 32'd0);
      if (bus.s_rvalid) chk("rresp", {30'd0, bus.s_rresp}, 32'd0);
      if (prev_rv && !prev_rrdy) begin
        chk("rvalid_hold", {31'd0, bus.s_rvalid}, 32'd1);
        chk("rdata_hold", bus.s_rdata, prev_rdata);
      end
      if (prev_bv && !prev_brdy) chk("bvalid_hold", {31'd0, bus.s_bvalid}, 32'd1);
      if (bus.s_rvalid && bus.s_rready) begin
        if (exp_rd.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
        else chk("rdata_model", bus.s_rdata, exp_rd.pop_front());
      end
      prev_rv = bus.s_rvalid;
      prev_rrdy = bus.s_rready;
      prev_rdata = bus.s_rdata;
      prev_bv = bus.s_bvalid;
      prev_brdy = bus.s_bready;
    end
  end

  task automatic do_write(input logic [AAW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] b);
    bus.s_awaddr = a; bus.s_awvalid = 1'b1;
    bus.s_wdata = d; bus.s_wstrb = b; bus.s_wvalid = 1'b1;
    exp_wr.push_back('{a[AAW-1:2], d, b});
    tick;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
    for (int i = 0; i < 20 && !bus.s_bvalid; i++) tick;
    chk("wr_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    tick;
    bus.s_bready = 1'b0;
    apply_write(a[AAW-1:2], d, b);
  endtask

  task automatic do_read(input logic [AAW-1:0] a, input logic [DW-1:0] lit);
    bus.s_araddr = a; bus.s_arvalid = 1'b1;
    exp_rd.push_back(shadow[a[AAW-1:2]]);
    tick;
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    for (int i = 0; i < 20 && !bus.s_rvalid; i++) tick;
    chk("rd_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
    chk("rd_literal", bus.s_rdata, lit);
    tick;
    bus.s_rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin ram[i] = '0; shadow[i] = '0; end
    mem_rd_data = '0;
    bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 0; bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0;
    bus.s_rready = 0;

    repeat (3) tick;
    chk("rst_awready", {31'd0, bus.s_awready}, 32'd0);
    chk("rst_arready", {31'd0, bus.s_arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bus.s_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.s_rvalid}, 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_wr_addr", {24'd0, mem_wr_addr}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_awready", {31'd0, bus.s_awready}, 32'd1);
    chk("idle_wready", {31'd0, bus.s_wready}, 32'd1);

    // AW and W together at T
    bus.s_awaddr = 10'h10; bus.s_awvalid = 1; bus.s_wdata = 32'hDEADBEEF;
    bus.s_wstrb = 4'hF; bus.s_wvalid = 1;
    exp_wr.push_back('{8'd4, 32'hDEADBEEF, 4'hF});
    tick;
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    chk("t1_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t1_wr_addr", {24'd0, mem_wr_addr}, 32'd4);
    chk("t1_be", {28'd0, mem_be}, 32'hF);
    chk("t1_bvalid_early", {31'd0, bus.s_bvalid}, 32'd0);
    tick;
    chk("t1_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    chk("t1_awready_busy", {31'd0, bus.s_awready}, 32'd0);
    bus.s_bready = 1;
    tick;
    bus.s_bready = 0;
    chk("t1_bvalid_done", {31'd0, bus.s_bvalid}, 32'd0);
    apply_write(8'd4, 32'hDEADBEEF, 4'hF);

    // W three cycles before AW
    bus.s_wdata = 32'h11223344; bus.s_wstrb = 4'b0101; bus.s_wvalid = 1;
    exp_wr.push_back('{8'd8, 32'h11223344, 4'b0101});
    tick;
    bus.s_wvalid = 0;
    chk("t2_wready_held1", {31'd0, bus.s_wready}, 32'd0);
    tick;
    chk("t2_wready_held2", {31'd0, bus.s_wready}, 32'd0);
    tick;
    bus.s_awaddr = 10'h20; bus.s_awvalid = 1;
    chk("t2_awready", {31'd0, bus.s_awready}, 32'd1);
    tick;
    bus.s_awvalid = 0;
    chk("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t2_wr_addr", {24'd0, mem_wr_addr}, 32'd8);
    chk("t2_be", {28'd0, mem_be}, 32'h5);
    tick;
    chk("t2_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    chk("t2_wready_resp", {31'd0, bus.s_wready}, 32'd0);
    bus.s_bready = 1;
    tick;
    bus.s_bready = 0;
    chk("t2_wready_idle", {31'd0, bus.s_wready}, 32'd1);
    apply_write(8'd8, 32'h11223344, 4'b0101);

    // Read 0x10 with 5 cycles of rready backpressure
    bus.s_araddr = 10'h10; bus.s_arvalid = 1;
    exp_rd.push_back(shadow[4]);
    chk("t3_arready", {31'd0, bus.s_arready}, 32'd1);
    tick;
    bus.s_arvalid = 0;
    chk("t3_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("t3_rd_addr", {24'd0, mem_rd_addr}, 32'd4);
    tick;
    chk("t3_mem_rd_once", {31'd0, mem_rd}, 32'd0);
    tick;
    chk("t3_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
    chk("t3_rdata", bus.s_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t3_bp_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
      chk("t3_bp_rdata", bus.s_rdata, 32'hDEADBEEF);
      chk("t3_bp_arready", {31'd0, bus.s_arready}, 32'd0);
    end
    bus.s_rready = 1;
    tick;
    bus.s_rready = 0;
    chk("t3_rvalid_done", {31'd0, bus.s_rvalid}, 32'd0);
    chk("t3_arready_idle", {31'd0, bus.s_arready}, 32'd1);

    do_read(10'h20, 32'h00220044);
    do_read(10'h13, 32'hDEADBEEF);

    // Write with bready backpressure
    bus.s_awaddr = 10'h40; bus.s_awvalid = 1; bus.s_wdata = 32'hA5A5A5A5;
    bus.s_wstrb = 4'hF; bus.s_wvalid = 1;
    exp_wr.push_back('{8'd16, 32'hA5A5A5A5, 4'hF});
    tick;
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
      chk("bp_awready", {31'd0, bus.s_awready}, 32'd0);
    end
    bus.s_bready = 1;
    tick;
    bus.s_bready = 0;
    chk("bp_bvalid_done", {31'd0, bus.s_bvalid}, 32'd0);
    apply_write(8'd16, 32'hA5A5A5A5, 4'hF);

    // Zero strobe leaves the word untouched
    do_write(10'h10, 32'hFFFFFFFF, 4'h0);
    do_read(10'h10, 32'hDEADBEEF);

    // Simultaneous write and read of 0x30
    bus.s_awaddr = 10'h30; bus.s_awvalid = 1; bus.s_wdata = 32'hCAFEF00D;
    bus.s_wstrb = 4'hF; bus.s_wvalid = 1;
    bus.s_araddr = 10'h30; bus.s_arvalid = 1;
    exp_wr.push_back('{8'd12, 32'hCAFEF00D, 4'hF});
    exp_rd.push_back(shadow[12]);
    bus.s_bready = 1; bus.s_rready = 1;
    tick;
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    chk("t4_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t4_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("t4_rd_addr", {24'd0, mem_rd_addr}, 32'd12);
    tick;
    chk("t4_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    tick;
    chk("t4_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
    chk("t4_rdata_old", bus.s_rdata, 32'h0);
    apply_write(8'd12, 32'hCAFEF00D, 4'hF);
    tick;
    bus.s_bready = 0; bus.s_rready = 0;
    chk("t4_rvalid_done", {31'd0, bus.s_rvalid}, 32'd0);
    do_read(10'h30, 32'hCAFEF00D);

    // Reset with the write in W_RESP and the read in R_MEM
    bus.s_awaddr = 10'h50; bus.s_awvalid = 1; bus.s_wdata = 32'h12345678;
    bus.s_wstrb = 4'hF; bus.s_wvalid = 1;
    exp_wr.push_back('{8'd20, 32'h12345678, 4'hF});
    tick;
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    tick;
    chk("t6_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    bus.s_araddr = 10'h40; bus.s_arvalid = 1;
    tick;
    bus.s_arvalid = 0;
    chk("t6_mem_rd", {31'd0, mem_rd}, 32'd1);
    rst = 1;
    chk("t6_rst_awready", {31'd0, bus.s_awready}, 32'd0);
    chk("t6_rst_wready", {31'd0, bus.s_wready}, 32'd0);
    tick;
    rst = 0;
    chk("t6_bvalid_clr", {31'd0, bus.s_bvalid}, 32'd0);
    chk("t6_rvalid_clr", {31'd0, bus.s_rvalid}, 32'd0);
    chk("t6_mem_rd_clr", {31'd0, mem_rd}, 32'd0);
    chk("t6_wr_addr_clr", {24'd0, mem_wr_addr}, 32'd0);
    bus.s_bready = 1; bus.s_rready = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t6_no_bvalid", {31'd0, bus.s_bvalid}, 32'd0);
      chk("t6_no_rvalid", {31'd0, bus.s_rvalid}, 32'd0);
    end
    bus.s_bready = 0; bus.s_rready = 0;
    do_write(10'h60, 32'h0BADCAFE, 4'hF);
    do_read(10'h60, 32'h0BADCAFE);

    tick;
    chk("exp_wr_drained", exp_wr.size(), 32'd0);
    chk("exp_rd_drained", exp_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
